dmem_responder: RTL and testbench

Data-memory responder for the MEM pipeline stage. It accepts one load/store request at a time over a valid/ready handshake and models a configurable number of wait states. It performs byte-enabled word writes and word reads on an internal synchronous array, then returns a single-cycle response with read data or an alignment error. The block is the memory-side end of the MEM-stage access path and replaces the direct RAM instance with a stall-capable interface.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_if.sv | 26 ++
 rtl/dmem_array.sv | 43 ++++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// Holds the FSM state encoding, bus widths and the alignment mask.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    localparam logic [1:0] MISALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb & MISALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage and the data memory.
// The master issues requests; the slave (responder) answers them.
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables.
// Reads are registered; a write clears the read register.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [BE_W-1:0]   i_be,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];
    logic [WORD_W-1:0] r_rdata;

    // Byte-merged write into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read port; stores return zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_en) begin
            r_rdata <= i_we ? '0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Stall-capable data-memory responder for the MEM stage.
// One request at a time, WAIT_CYCLES wait states, one-cycle response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    dmem_if.slave bus,
    output logic busy
);

    localparam logic [3:0] CNT_INIT =
        4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_word;
    logic              r_mis;
    logic [WORD_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_resp_valid;
    logic              r_resp_err;

    logic              w_idle;
    logic              w_accept;
    logic              w_enter_resp;
    logic              w_we;
    logic [ADDR_W-1:0] w_word;
    logic              w_mis;
    logic [WORD_W-1:0] w_wdata;
    logic [BE_W-1:0]   w_be;
    logic              w_arr_en;
    logic [WORD_W-1:0] w_arr_rdata;
    logic              w_unused_addr;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && bus.req_valid;

    // Access controls: live bus in IDLE (zero-wait path), captured regs otherwise.
    always_comb begin
        w_enter_resp = 1'b0;
        if (WAIT_CYCLES == 0) begin
            w_enter_resp = w_accept;
        end else begin
            w_enter_resp = (r_state == WAIT) && (r_cnt == 4'd0);
        end
        w_we    = w_idle ? bus.req_we : r_we;
        w_word  = w_idle ? bus.req_addr[ADDR_W+1:2] : r_word;
        w_mis   = w_idle ? is_misaligned(bus.req_addr[1:0]) : r_mis;
        w_wdata = w_idle ? bus.req_wdata : r_wdata;
        w_be    = w_idle ? bus.req_be : r_be;
    end

    assign w_arr_en      = w_enter_resp && !w_mis && !rst;
    assign w_unused_addr = ^bus.req_addr[WORD_W-1:ADDR_W+2];

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_arr_en),
        .i_we    (w_we),
        .i_addr  (w_word),
        .i_be    (w_be),
        .i_wdata (w_wdata),
        .o_rdata (w_arr_rdata)
    );

    // Request FSM: capture, count wait states, pulse the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_word       <= '0;
            r_mis        <= 1'b0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_word  <= bus.req_addr[ADDR_W+1:2];
                        r_mis   <= is_misaligned(bus.req_addr[1:0]);
                        r_wdata <= bus.req_wdata;
                        r_be    <= bus.req_be;
                        if (WAIT_CYCLES == 0) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_mis;
                        end else begin
                            r_cnt   <= CNT_INIT;
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= r_mis;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_idle;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_err ? '0 : w_arr_rdata;
    assign busy           = !w_idle;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states),
// a transaction-level memory model checked every cycle, plus directed cases.
module tb_dmem_responder;

    localparam int ADDR_W = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy2, busy0;

    dmem_if bus2 ();
    dmem_if bus0 ();

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut2 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus2),
        .busy (busy2)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus0),
        .busy (busy0)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          wc [2] = '{2, 0};
    int          k = 0;
    bit          started = 0;
    int          free_at [2];
    int          resp_edge [2];
    int          last_resp [2];
    bit          pend [2];
    logic        p_we [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wd [2];
    logic [3:0]  p_be [2];
    logic [31:0] e_rd [2];
    logic        e_err [2];
    logic [31:0] mem [int];

    task automatic model_step(input int d, input logic v, input logic we,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be);
        int key;
        logic [31:0] w;
        if (rst) begin
            pend[d]      = 0;
            free_at[d]   = k + 1;
            last_resp[d] = -10;
            e_rd[d]      = '0;
            e_err[d]     = 1'b0;
            return;
        end
        if (k >= free_at[d] && v) begin
            pend[d]      = 1;
            p_we[d]      = we;
            p_addr[d]    = a;
            p_wd[d]      = wd;
            p_be[d]      = be;
            resp_edge[d] = k + wc[d];
            free_at[d]   = k + wc[d] + 2;
        end
        if (pend[d] && k == resp_edge[d]) begin
            pend[d]      = 0;
            last_resp[d] = k;
            key = (d << ADDR_W) | int'(p_addr[d][ADDR_W+1:2]);
            if (p_addr[d][1:0] != 2'b00) begin
                e_err[d] = 1'b1;
                e_rd[d]  = '0;
            end else if (p_we[d]) begin
                w = mem.exists(key) ? mem[key] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (p_be[d][b]) w[8*b +: 8] = p_wd[d][8*b +: 8];
                mem[key] = w;
                e_err[d] = 1'b0;
                e_rd[d]  = '0;
            end else begin
                e_err[d] = 1'b0;
                e_rd[d]  = mem.exists(key) ? mem[key] : 32'hxxxx_xxxx;
            end
        end
    endtask

    always @(posedge clk) begin
        k = k + 1;
        if (rst) started = 1;
        model_step(0, bus2.req_valid, bus2.req_we, bus2.req_addr,
                   bus2.req_wdata, bus2.req_be);
        model_step(1, bus0.req_valid, bus0.req_we, bus0.req_addr,
                   bus0.req_wdata, bus0.req_be);
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        if (started) begin
            chk("w2.ready", {31'b0, bus2.req_ready}, {31'b0, (k + 1 >= free_at[0])});
            chk("w2.busy", {31'b0, busy2}, {31'b0, !(k + 1 >= free_at[0])});
            chk("w2.resp_valid", {31'b0, bus2.resp_valid}, {31'b0, last_resp[0] == k});
            chk("w2.rdata", bus2.resp_rdata, e_rd[0]);
            chk("w2.err", {31'b0, bus2.resp_err}, {31'b0, e_err[0]});
            chk("w0.ready", {31'b0, bus0.req_ready}, {31'b0, (k + 1 >= free_at[1])});
            chk("w0.busy", {31'b0, busy0}, {31'b0, !(k + 1 >= free_at[1])});
            chk("w0.resp_valid", {31'b0, bus0.resp_valid}, {31'b0, last_resp[1] == k});
            chk("w0.rdata", bus0.resp_rdata, e_rd[1]);
            chk("w0.err", {31'b0, bus0.resp_err}, {31'b0, e_err[1]});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle2();
        bus2.req_valid = 1'b0;
        bus2.req_we    = 1'b0;
        bus2.req_addr  = '0;
        bus2.req_wdata = '0;
        bus2.req_be    = '0;
    endtask

    task automatic req2(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output logic err,
                        output int lat, output int bc);
        int n = 0;
        bus2.req_valid = 1'b1;
        bus2.req_we    = we;
        bus2.req_addr  = a;
        bus2.req_wdata = wd;
        bus2.req_be    = be;
        rd = 'x; err = 'x; lat = -1; bc = 0;
        while (!bus2.req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            chk("accept_timeout", 32'(n), 32'(0));
            idle2();
            return;
        end
        @(posedge clk); #1;
        idle2();
        for (int i = 0; i < 50; i++) begin
            if (!busy2) break;
            bc++;
            if (bus2.resp_valid) begin
                lat = i;
                rd  = bus2.resp_rdata;
                err = bus2.resp_err;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) chk("resp_timeout", 32'hFFFF_FFFF, 32'h0);
    endtask

    task automatic abort_store(input logic [31:0] a, input logic [31:0] wd,
                               input int delay, output int pulses);
        bus2.req_valid = 1'b1;
        bus2.req_we    = 1'b1;
        bus2.req_addr  = a;
        bus2.req_wdata = wd;
        bus2.req_be    = 4'hF;
        @(posedge clk); #1;
        idle2();
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
        end
        pulses = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus2.resp_valid) pulses++;
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat, bc, pulses;
    logic [2:0]  seq;

    initial begin
        idle2();
        bus0.req_valid = 1'b0;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = '0;
        bus0.req_wdata = '0;
        bus0.req_be    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset.ready", {31'b0, bus2.req_ready}, 32'd1);
        chk("reset.rvalid", {31'b0, bus2.resp_valid}, 32'd0);
        chk("reset.rdata", bus2.resp_rdata, 32'h0);

        req2(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat, bc);
        chk("st10.rdata", rd, 32'h0);
        chk("st10.lat", 32'(lat), 32'd2);
        req2(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, bc);
        chk("ld10.rdata", rd, 32'hDEADBEEF);
        chk("ld10.err", {31'b0, err}, 32'd0);
        chk("ld10.lat", 32'(lat), 32'd2);

        req2(1'b1, 32'h20, 32'h11223344, 4'hF, rd, err, lat, bc);
        req2(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, err, lat, bc);
        req2(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, err, lat, bc);
        chk("st20.be0.lat", 32'(lat), 32'd2);
        req2(1'b0, 32'h20, 32'h0, 4'h0, rd, err, lat, bc);
        chk("ld20.merge", rd, 32'h11BB33DD);

        req2(1'b0, 32'h13, 32'h0, 4'h0, rd, err, lat, bc);
        chk("ld13.err", {31'b0, err}, 32'd1);
        chk("ld13.rdata", rd, 32'h0);
        chk("ld13.busy_cycles", 32'(bc), 32'd3);
        req2(1'b1, 32'h12, 32'h12345678, 4'hF, rd, err, lat, bc);
        chk("st12.err", {31'b0, err}, 32'd1);
        req2(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, bc);
        chk("ld10.unchanged", rd, 32'hDEADBEEF);

        req2(1'b1, 32'h40, 32'h0, 4'hF, rd, err, lat, bc);
        req2(1'b1, 32'h44, 32'h0, 4'hF, rd, err, lat, bc);
        abort_store(32'h40, 32'hCAFEF00D, 0, pulses);
        chk("abort_wait.pulses", 32'(pulses), 32'd0);
        req2(1'b0, 32'h40, 32'h0, 4'h0, rd, err, lat, bc);
        chk("abort_wait.ld40", rd, 32'h0);
        abort_store(32'h44, 32'hCAFEF00D, 1, pulses);
        chk("abort_edge.pulses", 32'(pulses), 32'd0);
        req2(1'b0, 32'h44, 32'h0, 4'h0, rd, err, lat, bc);
        chk("abort_edge.ld44", rd, 32'h0);

        req2(1'b1, 32'h0001_0008, 32'h5A5A5A5A, 4'hF, rd, err, lat, bc);
        req2(1'b0, 32'h8, 32'h0, 4'h0, rd, err, lat, bc);
        chk("wrap.ld8", rd, 32'h5A5A5A5A);

        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = 32'h100;
        bus0.req_wdata = 32'h01020304;
        bus0.req_be    = 4'hF;
        @(posedge clk); #1;
        seq[2] = bus0.resp_valid;
        bus0.req_addr  = 32'h104;
        bus0.req_wdata = 32'h0A0B0C0D;
        @(posedge clk); #1;
        seq[1] = bus0.resp_valid;
        @(posedge clk); #1;
        seq[0] = bus0.resp_valid;
        bus0.req_valid = 1'b0;
        chk("w0.pulse_seq", {29'b0, seq}, 32'b101);
        @(posedge clk); #1;
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = 32'h100;
        @(posedge clk); #1;
        chk("w0.ld100", bus0.resp_rdata, 32'h01020304);
        bus0.req_valid = 1'b0;
        @(posedge clk); #1;
        bus0.req_valid = 1'b1;
        bus0.req_addr  = 32'h104;
        @(posedge clk); #1;
        chk("w0.ld104", bus0.resp_rdata, 32'h0A0B0C0D);
        bus0.req_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
